axis_keep_packer: RTL

- Receives an AXI-Stream whose tkeep may be sparse or non-contiguous, e.g. short tails or null beats produced by upstream width conversion.
- Re-emits the same byte sequence at the same width, densely packed: every output beat has all bytes kept, except the final beat of a packet, whose kept bytes are contiguous from byte 0.
- Sits on the receive side of width-converted streams, ahead of blocks that require dense tkeep (framers, checksums, FIFOs that count bytes).

---
 rtl/axis_keep_packer.sv | 112 +++++++++++
 1 files changed

// File: rtl/axis_keep_packer.sv
// Purpose: repacks an AXI-Stream with sparse tkeep into dense beats (only the packet tail may be partial).
// Latency: a byte accepted in cycle t can appear on the output in cycle t+1; all outputs are registered state.
// Backpressure: input ready is registered and drops while 2N-byte buffer holds more than N bytes or a tail is pending.
module axis_keep_packer #(
  parameter int AXIS_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    areset,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic                    axis_i_tlast,
  input  logic [AXIS_BYTES-1:0]   axis_i_tkeep,
  input  logic [8*AXIS_BYTES-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [AXIS_BYTES-1:0]   axis_o_tkeep,
  output logic [8*AXIS_BYTES-1:0] axis_o_tdata
);

  localparam int N  = AXIS_BYTES;
  localparam int B  = 2 * N;
  localparam int CW = $clog2(B + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  logic [7:0]    byte_buf [B];
  logic [7:0]    buf_next [B];
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] take;
  logic [CW-1:0] popped;
  logic          last_pending;
  logic          last_next;
  logic          rdy_q;
  logic          full_word;
  logic          push;
  logic          pop;

  // A full word is available once N bytes are buffered; otherwise only the tail can go out.
  assign full_word     = (cnt >= N_CNT);
  assign take          = full_word ? N_CNT : cnt;
  assign axis_i_tready = rdy_q;
  assign axis_o_tvalid = full_word | last_pending;
  assign axis_o_tlast  = last_pending & (cnt <= N_CNT);
  assign push          = axis_i_tvalid & rdy_q;
  assign pop           = axis_o_tvalid & axis_o_tready;
  assign popped        = pop ? take : '0;

  // Present the lowest min(cnt,N) buffered bytes; unused lanes read as zero.
  always_comb begin
    axis_o_tkeep = '0;
    axis_o_tdata = '0;
    for (int k = 0; k < N; k++) begin
      if (CW'(k) < take) begin
        axis_o_tkeep[k]        = 1'b1;
        axis_o_tdata[8*k +: 8] = byte_buf[k];
      end
    end
  end

  // Drop the popped bytes, then append the compacted input bytes above what remains.
  always_comb begin
    int wr;
    for (int j = 0; j < B; j++) begin
      buf_next[j] = '0;
      if (j + int'(popped) < B) begin
        buf_next[j] = byte_buf[j + int'(popped)];
      end
    end
    wr = int'(cnt) - int'(popped);
    if (push) begin
      for (int k = 0; k < N; k++) begin
        if (axis_i_tkeep[k]) begin
          // Push is only allowed with cnt <= N, so wr never passes 2N-1 here.
          if (wr < B) begin
            buf_next[wr] = axis_i_tdata[8*k +: 8];
          end
          wr = wr + 1;
        end
      end
    end
    cnt_next = CW'(wr);
    // Setting and clearing cannot coincide: push needs !last_pending, a tlast pop needs last_pending.
    last_next = last_pending;
    if (pop && axis_o_tlast) begin
      last_next = 1'b0;
    end
    if (push && axis_i_tlast) begin
      last_next = 1'b1;
    end
  end

  // State registers; input ready is precomputed from next state so it never depends on inputs.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int j = 0; j < B; j++) begin
        byte_buf[j] <= '0;
      end
      cnt          <= '0;
      last_pending <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      for (int j = 0; j < B; j++) begin
        byte_buf[j] <= buf_next[j];
      end
      cnt          <= cnt_next;
      last_pending <= last_next;
      rdy_q        <= ~last_next & (cnt_next <= N_CNT);
    end
  end

endmodule
